// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter that lends one serial "1001" detector to NREQ lanes,
// one FRAME_LEN-bit frame at a time, and reports the match count per frame.
module seq_det_arbiter #(
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 5,
    parameter int ID_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  din,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic             done,
    output logic [ID_W-1:0]  done_id,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BC_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_owner;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [BC_W-1:0]  bit_cnt;
    logic [2:0]       hist;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sample;
    logic             hit;
    logic             last_bit;

    // Walk downward so the closest requester after last_owner is written last and wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand       = '0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IDX_W'((int'(last_owner) + i) % NREQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign sample   = din[owner];
    assign hit      = ({hist, sample} == 4'b1001);
    assign cnt_next = (hit && (run_cnt != '1)) ? run_cnt + CNT_W'(1) : run_cnt;
    assign last_bit = (bit_cnt == BC_W'(FRAME_LEN - 1));

    assign busy = (state != IDLE);
    assign done = (state == REPORT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            last_owner <= IDX_W'(NREQ - 1);
            bit_cnt    <= '0;
            hist       <= 3'b000;
            run_cnt    <= '0;
            done_id    <= '0;
            match_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt        <= NREQ'(1) << pick_idx;
                        owner      <= pick_idx;
                        last_owner <= pick_idx;
                        bit_cnt    <= '0;
                        hist       <= 3'b000;
                        run_cnt    <= '0;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    hist    <= {hist[1:0], sample};
                    run_cnt <= cnt_next;
                    bit_cnt <= bit_cnt + BC_W'(1);
                    // The final sample's match lands in match_cnt via cnt_next.
                    if (last_bit) begin
                        gnt       <= '0;
                        done_id   <= ID_W'(owner);
                        match_cnt <= cnt_next;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Bench for seq_det_arbiter: a frame-level reference model checked every cycle,
// plus literal expectations for each directed frame.
module tb_seq_det_arbiter;

    localparam int NREQ = 4;
    localparam int FL   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] din = '0;

    logic [3:0] gnt, gnt2;
    logic       busy, busy2, done, done2;
    logic [1:0] doneId, doneId2;
    logic [4:0] matchCnt;
    logic [1:0] matchCnt2;

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 1'b0;

    always #5 clk = ~clk;

    seq_det_arbiter #(.NREQ(4), .FRAME_LEN(FL), .CNT_W(5), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .busy(busy),
        .done(done), .done_id(doneId), .match_cnt(matchCnt)
    );

    seq_det_arbiter #(.NREQ(4), .FRAME_LEN(FL), .CNT_W(2), .ID_W(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt2), .busy(busy2),
        .done(done2), .done_id(doneId2), .match_cnt(matchCnt2)
    );

    // Reference model: phase -1 is idle, 0..FL-1 counts samples taken, FL is the report cycle.
    int         phase     = -1;
    int         mOwner    = 0;
    int         lastOwner = NREQ - 1;
    int         raw       = 0;
    bit         frameBits[$];
    logic [3:0] eGnt  = '0;
    logic       eBusy = 1'b0;
    logic       eDone = 1'b0;
    logic [1:0] eId   = '0;
    logic [4:0] eCnt5 = '0;
    logic [1:0] eCnt2 = '0;

    function automatic int countPattern();
        int n = 0;
        for (int k = 3; k < frameBits.size(); k++)
            if (frameBits[k-3] && !frameBits[k-2] && !frameBits[k-1] && frameBits[k]) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            phase     = -1;
            lastOwner = NREQ - 1;
            eId       = '0;
            eCnt5     = '0;
            eCnt2     = '0;
        end else if (phase < 0) begin
            for (int i = NREQ; i >= 1; i--)
                if (req[(lastOwner + i) % NREQ]) begin
                    mOwner = (lastOwner + i) % NREQ;
                    phase  = 0;
                end
            if (phase == 0) begin
                lastOwner = mOwner;
                frameBits.delete();
            end
        end else if (phase < FL) begin
            frameBits.push_back(din[mOwner]);
            phase++;
            if (phase == FL) begin
                raw   = countPattern();
                eId   = 2'(mOwner);
                eCnt5 = 5'((raw > 31) ? 31 : raw);
                eCnt2 = 2'((raw > 3) ? 3 : raw);
            end
        end else begin
            phase = -1;
        end
        eGnt  = (phase >= 0 && phase < FL) ? 4'(1 << mOwner) : 4'b0000;
        eBusy = (phase >= 0);
        eDone = (phase == FL);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("gnt", 32'(gnt), 32'(eGnt));
            checkOutput("busy", 32'(busy), 32'(eBusy));
            checkOutput("done", 32'(done), 32'(eDone));
            checkOutput("done_id", 32'(doneId), 32'(eId));
            checkOutput("match_cnt", 32'(matchCnt), 32'(eCnt5));
            checkOutput("gnt_w2", 32'(gnt2), 32'(eGnt));
            checkOutput("busy_w2", 32'(busy2), 32'(eBusy));
            checkOutput("done_w2", 32'(done2), 32'(eDone));
            checkOutput("done_id_w2", 32'(doneId2), 32'(eId));
            checkOutput("match_cnt_w2", 32'(matchCnt2), 32'(eCnt2));
        end
    end

    // Caller sits at a negedge with the DUT idle; returns at the negedge of the next idle cycle.
    task automatic applyStimulus(input logic [3:0] r, input logic [15:0] pat, input int expOwner,
                                 input int expCnt5, input int expCnt2, input int dropBit);
        logic [3:0] oneHot;
        int         gntCycles;
        oneHot    = 4'(1 << expOwner);
        gntCycles = 0;
        req       = r;
        @(negedge clk);
        for (int k = 0; k < FL; k++) begin
            if (gnt == oneHot) gntCycles++;
            din = pat[15-k] ? oneHot : ~oneHot;
            if (k == 8 && dropBit >= 0) req[dropBit] = 1'b0;
            @(negedge clk);
        end
        din = '0;
        checkOutput("frame_len", 32'(gntCycles), 32'(FL));
        checkOutput("lit_done", 32'(done), 32'd1);
        checkOutput("lit_id", 32'(doneId), 32'(expOwner));
        checkOutput("lit_cnt", 32'(matchCnt), 32'(expCnt5));
        checkOutput("lit_cnt_w2", 32'(matchCnt2), 32'(expCnt2));
        @(negedge clk);
        checkOutput("lit_idle_gnt", 32'(gnt), 32'd0);
        checkOutput("lit_idle_done", 32'(done), 32'd0);
    endtask

    task automatic resetDut();
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        checkEn = 1'b1;
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_id", 32'(doneId), 32'd0);
        checkOutput("rst_cnt", 32'(matchCnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] single requester and overlap counting");
        applyStimulus(4'b0001, 16'h9000, 0, 1, 1, -1);
        applyStimulus(4'b0100, 16'h9240, 2, 3, 3, -1);
        applyStimulus(4'b0100, 16'hFFFF, 2, 0, 0, -1);
        applyStimulus(4'b0100, 16'h0009, 2, 1, 1, -1);

        $display("[TB] two requesters held from reset");
        resetDut();
        applyStimulus(4'b0101, 16'h9000, 0, 1, 1, -1);
        applyStimulus(4'b0101, 16'h9240, 2, 3, 3, -1);
        applyStimulus(4'b0101, 16'h0009, 0, 1, 1, -1);
        applyStimulus(4'b0101, 16'h9000, 2, 1, 1, -1);

        $display("[TB] all requesters, req[1] dropped mid-frame");
        resetDut();
        applyStimulus(4'b1111, 16'h9000, 0, 1, 1, -1);
        applyStimulus(4'b1111, 16'h9240, 1, 3, 3, 1);
        applyStimulus(4'b1111, 16'h0009, 2, 1, 1, -1);
        applyStimulus(4'b1111, 16'hFFFF, 3, 0, 0, -1);
        applyStimulus(4'b1111, 16'h9000, 0, 1, 1, -1);

        $display("[TB] saturation");
        applyStimulus(4'b0010, 16'h9249, 1, 5, 3, -1);

        $display("[TB] reset mid-frame");
        req = 4'b0100;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            din = (k == 0 || k == 3 || k == 6) ? 4'b0100 : 4'b1011;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        checkOutput("abort_gnt", 32'(gnt), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_id", 32'(doneId), 32'd0);
        checkOutput("abort_cnt", 32'(matchCnt), 32'd0);
        @(negedge clk);
        checkOutput("abort_nodone", 32'(done), 32'd0);
        applyStimulus(4'b1100, 16'h0009, 2, 1, 1, -1);

        @(negedge clk);
        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not reach the end");
        $fatal(1, "[TB] timeout");
    end

endmodule
